// File: rtl/keypad_entry_if.sv
// Signal bundle between the keypad front end (rows + scanner code) and the
// entry block: raw inputs in, debounced key events and entry buffer out.
interface keypad_entry_if;
  logic [3:0]  row;
  logic [3:0]  key_in;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic        entry_done;
  logic [15:0] entry_value;
  logic        entry_err;

  modport master (
    output row, key_in,
    input  key_valid, key_code, digits, digit_count,
    input  entry_done, entry_value, entry_err
  );

  modport slave (
    input  row, key_in,
    output key_valid, key_code, digits, digit_count,
    output entry_done, entry_value, entry_err
  );
endinterface

// File: rtl/keypad_entry.sv
// Debounces keypad row activity into one key event per press, then assembles
// events into a 4-digit BCD entry buffer with clear, backspace and enter.
module keypad_entry #(
  parameter int SETTLE_CYCLES  = 32,
  parameter int RELEASE_CYCLES = 500000
) (
  input logic           clk_100MHz,
  input logic           reset,
  keypad_entry_if.slave kp
);

  localparam int MAX_CYC = (SETTLE_CYCLES > RELEASE_CYCLES) ? SETTLE_CYCLES : RELEASE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} press_state_t;

  logic [3:0]   row_p0;
  logic [3:0]   row_s;
  logic         active;
  press_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         sample;

  logic         key_valid_q;
  logic [3:0]   key_code_q;
  logic [15:0]  digits_q;
  logic [2:0]   count_q;
  logic         entry_done_q;
  logic [15:0]  entry_value_q;
  logic         entry_err_q;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      row_p0 <= 4'hF;
      row_s  <= 4'hF;
    end else begin
      row_p0 <= kp.row;
      row_s  <= row_p0;
    end
  end

  assign active = (row_s != 4'hF);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // SETTLE ignores the row so press bounce cannot restart the settle window;
  // HELD restarts the release count on any activity so release bounce merges.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sample  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (active) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          sample  = 1'b1;
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (active) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(RELEASE_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Stage p2: key event capture, then the entry buffer acts one cycle later
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      key_valid_q   <= 1'b0;
      key_code_q    <= 4'h0;
      digits_q      <= 16'h0000;
      count_q       <= 3'd0;
      entry_done_q  <= 1'b0;
      entry_value_q <= 16'h0000;
      entry_err_q   <= 1'b0;
    end else begin
      key_valid_q  <= sample;
      entry_done_q <= 1'b0;
      entry_err_q  <= 1'b0;
      if (sample) begin
        key_code_q <= kp.key_in;
      end
      if (key_valid_q) begin
        if (is_digit(key_code_q)) begin
          if (count_q < 3'd4) begin
            digits_q <= {digits_q[11:0], key_code_q};
            count_q  <= count_q + 3'd1;
          end else begin
            entry_err_q <= 1'b1;
          end
        end else begin
          unique case (key_code_q)
            4'hB: begin
              if (count_q != 3'd0) begin
                digits_q <= {4'h0, digits_q[15:4]};
                count_q  <= count_q - 3'd1;
              end else begin
                entry_err_q <= 1'b1;
              end
            end
            4'hE: begin
              if (count_q != 3'd0) begin
                entry_value_q <= digits_q;
                entry_done_q  <= 1'b1;
                digits_q      <= 16'h0000;
                count_q       <= 3'd0;
              end else begin
                entry_err_q <= 1'b1;
              end
            end
            4'hF: begin
              digits_q <= 16'h0000;
              count_q  <= 3'd0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign kp.key_valid   = key_valid_q;
  assign kp.key_code    = key_code_q;
  assign kp.digits      = digits_q;
  assign kp.digit_count = count_q;
  assign kp.entry_done  = entry_done_q;
  assign kp.entry_value = entry_value_q;
  assign kp.entry_err   = entry_err_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with short settle/release windows and a
// scanner model that presents the key code 10 cycles after the row drops.
module tb_keypad_entry;

  logic clk_100MHz = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  keypad_entry_if kp ();

  keypad_entry #(.SETTLE_CYCLES(16), .RELEASE_CYCLES(200)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .kp         (kp)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One press: called just after a posedge; t counts cycles from the row drop.
  task automatic press(input logic [3:0] code, input int hold, input int gap, input bit bounce,
                       output int nvalid, output int lat, output int ndone, output int nerr);
    nvalid = 0; lat = -1; ndone = 0; nerr = 0;
    for (int t = 0; t < hold + gap; t++) begin
      if (t < hold)
        kp.row = (bounce && t < 60 && ((t / 5) % 2 == 1)) ? 4'hF : 4'hB;
      else
        kp.row = (bounce && t < hold + 60 && (((t - hold) / 5) % 2 == 1)) ? 4'hB : 4'hF;
      if (t == 10) kp.key_in = code;
      @(negedge clk_100MHz);
      if (kp.key_valid) begin
        if (nvalid == 0) lat = t;
        nvalid++;
      end
      if (kp.entry_done) ndone++;
      if (kp.entry_err) nerr++;
      @(posedge clk_100MHz);
      #1;
    end
  endtask

  initial begin
    int nv, lat, nd, ne;
    reset = 1'b1;
    kp.row = 4'hF;
    kp.key_in = 4'h0;
    repeat (3) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    chk("rst_key_valid", 32'(kp.key_valid), 32'd0);
    chk("rst_key_code", 32'(kp.key_code), 32'd0);
    chk("rst_digits", 32'(kp.digits), 32'd0);
    chk("rst_count", 32'(kp.digit_count), 32'd0);
    chk("rst_done_err", 32'({kp.entry_done, kp.entry_err}), 32'd0);
    chk("rst_entry_value", 32'(kp.entry_value), 32'd0);
    @(posedge clk_100MHz);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk_100MHz);
    #1;

    // Single press of 5: key_valid 19 edges after the row drop
    press(4'h5, 300, 300, 1'b0, nv, lat, nd, ne);
    chk("p5_nvalid", 32'(nv), 32'd1);
    chk("p5_latency", 32'(lat), 32'd19);
    chk("p5_key_code", 32'(kp.key_code), 32'h5);
    chk("p5_digits", 32'(kp.digits), 32'h0005);
    chk("p5_count", 32'(kp.digit_count), 32'd1);
    chk("p5_err", 32'(ne), 32'd0);

    press(4'hF, 300, 300, 1'b0, nv, lat, nd, ne);
    chk("clr_digits", 32'(kp.digits), 32'h0000);
    chk("clr_err", 32'(ne), 32'd0);

    // Fill the buffer, then overflow
    press(4'h1, 300, 300, 1'b0, nv, lat, nd, ne);
    press(4'h2, 300, 300, 1'b0, nv, lat, nd, ne);
    press(4'h3, 300, 300, 1'b0, nv, lat, nd, ne);
    press(4'h4, 300, 300, 1'b0, nv, lat, nd, ne);
    chk("fill_digits", 32'(kp.digits), 32'h1234);
    chk("fill_count", 32'(kp.digit_count), 32'd4);
    press(4'h5, 300, 300, 1'b0, nv, lat, nd, ne);
    chk("ovf_err", 32'(ne), 32'd1);
    chk("ovf_digits", 32'(kp.digits), 32'h1234);
    chk("ovf_count", 32'(kp.digit_count), 32'd4);

    // Backspace then enter
    press(4'hB, 300, 300, 1'b0, nv, lat, nd, ne);
    chk("bs_digits", 32'(kp.digits), 32'h0123);
    chk("bs_count", 32'(kp.digit_count), 32'd3);
    press(4'hE, 300, 300, 1'b0, nv, lat, nd, ne);
    chk("ent_done", 32'(nd), 32'd1);
    chk("ent_err", 32'(ne), 32'd0);
    chk("ent_value", 32'(kp.entry_value), 32'h0123);
    chk("ent_digits", 32'(kp.digits), 32'h0000);
    chk("ent_count", 32'(kp.digit_count), 32'd0);

    // Bouncy press of 7
    press(4'h7, 300, 300, 1'b1, nv, lat, nd, ne);
    chk("bnc_nvalid", 32'(nv), 32'd1);
    chk("bnc_digits", 32'(kp.digits), 32'h0007);
    chk("bnc_count", 32'(kp.digit_count), 32'd1);

    press(4'hF, 300, 300, 1'b0, nv, lat, nd, ne);
    press(4'hE, 300, 300, 1'b0, nv, lat, nd, ne);
    chk("e_empty_err", 32'(ne), 32'd1);
    chk("e_empty_done", 32'(nd), 32'd0);
    chk("e_empty_value", 32'(kp.entry_value), 32'h0123);
    press(4'hB, 300, 300, 1'b0, nv, lat, nd, ne);
    chk("b_empty_err", 32'(ne), 32'd1);
    chk("b_empty_count", 32'(kp.digit_count), 32'd0);

    press(4'h4, 300, 300, 1'b0, nv, lat, nd, ne);
    press(4'h2, 300, 300, 1'b0, nv, lat, nd, ne);
    press(4'hA, 300, 300, 1'b0, nv, lat, nd, ne);
    chk("a_ignored_err", 32'(ne), 32'd0);
    chk("a_ignored_digits", 32'(kp.digits), 32'h0042);
    chk("a_ignored_count", 32'(kp.digit_count), 32'd2);
    press(4'hF, 300, 300, 1'b0, nv, lat, nd, ne);
    chk("f2_err", 32'(ne), 32'd0);
    chk("f2_digits", 32'(kp.digits), 32'h0000);
    chk("f2_count", 32'(kp.digit_count), 32'd0);
    chk("f2_value", 32'(kp.entry_value), 32'h0123);

    press(4'h8, 300, 300, 1'b0, nv, lat, nd, ne);
    chk("pre_rst_digits", 32'(kp.digits), 32'h0008);

    // Reset 8 cycles into SETTLE with the key still held
    nv = 0;
    for (int t = 0; t <= 10; t++) begin
      kp.row = 4'hB;
      if (t == 10) kp.key_in = 4'h9;
      @(negedge clk_100MHz);
      if (kp.key_valid) nv++;
      @(posedge clk_100MHz);
      #1;
    end
    chk("mid_settle_nvalid", 32'(nv), 32'd0);
    reset = 1'b1;
    @(posedge clk_100MHz);
    #1;
    chk("mrst_key_valid", 32'(kp.key_valid), 32'd0);
    chk("mrst_key_code", 32'(kp.key_code), 32'd0);
    chk("mrst_digits", 32'(kp.digits), 32'd0);
    chk("mrst_count", 32'(kp.digit_count), 32'd0);
    chk("mrst_value", 32'(kp.entry_value), 32'd0);
    @(posedge clk_100MHz);
    #1;
    reset = 1'b0;
    nv = 0; lat = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk_100MHz);
      if (kp.key_valid) begin
        if (nv == 0) lat = t;
        nv++;
      end
      @(posedge clk_100MHz);
      #1;
    end
    chk("post_rst_nvalid", 32'(nv), 32'd1);
    chk("post_rst_latency", 32'(lat), 32'd19);
    chk("post_rst_key_code", 32'(kp.key_code), 32'h9);
    kp.row = 4'hF;
    repeat (300) @(posedge clk_100MHz);
    #1;
    chk("post_rst_digits", 32'(kp.digits), 32'h0009);
    chk("post_rst_count", 32'(kp.digit_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
